// File: rtl/genius_pkg.sv
// Shared types and widths for the Genius (Simon) round sequencer.
package genius_pkg;

  localparam int COLOR_W = 4;
  localparam int ADDR_W  = 4;
  localparam int ROUND_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    WAIT_REL,
    WIN,
    LOSE
  } genius_state_t;

  typedef struct packed {
    logic busy;
    logic win;
    logic lose;
  } genius_status_t;

  // Status flags that go with a given state.
  function automatic genius_status_t status_of(input genius_state_t s);
    genius_status_t st;
    st.busy = (s != IDLE) && (s != WIN) && (s != LOSE);
    st.win  = (s == WIN);
    st.lose = (s == LOSE);
    return st;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/genius_seq_ctrl_if.sv
// Game-side signals of the sequencer: buttons, sequence decoder link, LEDs, status.
interface genius_seq_ctrl_if;
  import genius_pkg::*;

  logic               start;
  logic [COLOR_W-1:0] botoes;
  logic [ADDR_W-1:0]  seq_addr;
  logic [COLOR_W-1:0] seq_data;
  logic [COLOR_W-1:0] leds;
  logic [ROUND_W-1:0] rodada;
  logic               busy;
  logic               win;
  logic               lose;

  // Sequencer side.
  modport master (
    input  start, botoes, seq_data,
    output seq_addr, leds, rodada, busy, win, lose
  );

  // Surrounding board: buttons, decoder and displays.
  modport slave (
    output start, botoes, seq_data,
    input  seq_addr, leds, rodada, busy, win, lose
  );
endinterface

// File: rtl/genius_timer.sv
// Loadable down-counter timing the on, off and timeout phases.
// done_o is high while the loaded count has run out; a load of N-1 gives N cycles.
module genius_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/genius_seq_ctrl.sv
// Genius round sequencer: plays the sequence ROM on the LEDs, then checks the
// player's presses against it, growing the round by one until MAX_ROUND.
module genius_seq_ctrl
  import genius_pkg::*;
#(
  parameter int TICKS_ON  = 25_000_000,
  parameter int TICKS_OFF = 12_500_000,
  parameter int TIMEOUT   = 250_000_000,
  parameter int MAX_ROUND = 16
) (
  input logic                clk,
  input logic                reset,
  genius_seq_ctrl_if.master  bus
);

  localparam int TICK_MAX = max3(TICKS_ON, TICKS_OFF, TIMEOUT);
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TICK_W-1:0]  LOAD_ON    = TICK_W'(TICKS_ON - 1);
  localparam logic [TICK_W-1:0]  LOAD_OFF   = TICK_W'(TICKS_OFF - 1);
  localparam logic [TICK_W-1:0]  LOAD_TO    = TICK_W'(TIMEOUT - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND);
  localparam logic [ROUND_W-1:0] ONE_R      = ROUND_W'(1);
  localparam logic [ADDR_W-1:0]  ONE_A      = ADDR_W'(1);

  genius_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ROUND_W-1:0] rodada_q, rodada_d;
  logic [COLOR_W-1:0] botoes_q;
  genius_status_t     status_q;

  logic               timer_load;
  logic [TICK_W-1:0]  timer_val;
  logic               timer_done;

  logic [ROUND_W-1:0] idx_ext;
  logic               last_idx;
  logic               press;

  genius_timer #(.W(TICK_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  assign idx_ext  = ROUND_W'(idx_q);
  assign last_idx = !(idx_ext < rodada_q - ONE_R);
  assign press    = (bus.botoes != '0) && (botoes_q == '0);

  // Next-state, index/round update and timer reload for each phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    idx_d      = idx_q;
    rodada_d   = rodada_q;
    timer_load = 1'b0;
    timer_val  = LOAD_OFF;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          rodada_d   = ONE_R;
          idx_d      = '0;
          timer_load = 1'b1;
          timer_val  = LOAD_OFF;
          state_d    = SHOW_OFF;
        end
      end
      SHOW_OFF: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = LOAD_ON;
          state_d    = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (timer_done) begin
          timer_load = 1'b1;
          if (last_idx) begin
            idx_d     = '0;
            timer_val = LOAD_TO;
            state_d   = WAIT_IN;
          end else begin
            idx_d     = idx_q + ONE_A;
            timer_val = LOAD_OFF;
            state_d   = SHOW_OFF;
          end
        end
      end
      WAIT_IN: begin
        // Press takes priority over a timeout expiring in the same cycle.
        if (press) begin
          state_d = (bus.botoes == bus.seq_data) ? WAIT_REL : LOSE;
        end else if (timer_done) begin
          state_d = LOSE;
        end
      end
      WAIT_REL: begin
        if (bus.botoes == '0) begin
          if (!last_idx) begin
            idx_d      = idx_q + ONE_A;
            timer_load = 1'b1;
            timer_val  = LOAD_TO;
            state_d    = WAIT_IN;
          end else if (rodada_q == LAST_ROUND) begin
            state_d = WIN;
          end else begin
            rodada_d   = rodada_q + ONE_R;
            idx_d      = '0;
            timer_load = 1'b1;
            timer_val  = LOAD_OFF;
            state_d    = SHOW_OFF;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, button history and status flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from the same pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rodada_q <= '0;
      botoes_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rodada_q <= rodada_d;
      botoes_q <= bus.botoes;
      status_q <= status_of(state_d);
    end
  end

  // LED source follows the current phase; seq_data and botoes pass straight through.
  always_comb begin
    bus.leds = '0;
    case (state_q)
      SHOW_ON:           bus.leds = bus.seq_data;
      WAIT_IN, WAIT_REL: bus.leds = bus.botoes;
      WIN:               bus.leds = '1;
      default:           bus.leds = '0;
    endcase
  end

  assign bus.seq_addr = idx_q;
  assign bus.rodada   = rodada_q;
  assign bus.busy     = status_q.busy;
  assign bus.win      = status_q.win;
  assign bus.lose     = status_q.lose;

endmodule

// File: doc/genius_seq_ctrl.md
# genius_seq_ctrl

Round sequencer for the Genius (Simon) memory game. It walks the sequence ROM address by address, plays the one-hot colour pattern on the LEDs with fixed on/off timing, then checks the player's button presses against the same ROM entries. On each fully correct round it grows the sequence by one, up to `MAX_ROUND`. It sits between the debounced button inputs, the 4-bit-address sequence decoder and the LED/status outputs.

## Interface
- `TICKS_ON`, default 25_000_000: cycles each colour is lit during playback (≥1).
- `TICKS_OFF`, default 12_500_000: dark gap after each colour, and before each new round's playback (≥1).
- `TIMEOUT`, default 250_000_000: cycles allowed between player presses (≥1).
- `MAX_ROUND`, default 16: winning round length (1..16).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level, sampled each cycle; honoured only in IDLE, WIN, LOSE.
- `botoes` in 4: debounced player buttons, one bit per colour, level.
- `seq_addr` out 4: registered address to sequence decoder.
- `seq_data` in 4: one-hot colour from decoder, combinational from `seq_addr`.
- `leds` out 4: colour LEDs.
- `rodada` out 5: current round length (0 in IDLE).
- `busy` out 1: high in every state except IDLE, WIN, LOSE.
- `win` out 1: high in WIN.
- `lose` out 1: high in LOSE.

## Operation
- States: IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, WAIT_REL, WIN, LOSE.
- Registers: `idx` (4 b, drives `seq_addr`), `rodada` (5 b), `tick` counter sized `$clog2` of the largest tick parameter, `botoes_q` (previous `botoes`).
- Reset: state IDLE, `idx`=0, `rodada`=0, `tick`=0, `botoes_q`=0. Outputs: `leds`=0, `seq_addr`=0, `busy`=`win`=`lose`=0.
- IDLE/WIN/LOSE with `start`=1 → `rodada`=1, `idx`=0, `tick`=0, go SHOW_OFF (leading gap).
- SHOW_OFF: `leds`=0. After `TICKS_OFF` cycles → SHOW_ON.
- SHOW_ON: `leds`=`seq_data`. After `TICKS_ON` cycles:
  - if `idx`==`rodada`−1 → `idx`=0, WAIT_IN;
  - else `idx`++ and SHOW_OFF.
- WAIT_IN: `leds`=`botoes`. A press is detected when `botoes`≠0 and `botoes_q`==0.
  - On a press: if `botoes`==`seq_data` → WAIT_REL; else → LOSE. Multi-bit presses never match, so they lose.
  - With no press for `TIMEOUT` consecutive cycles → LOSE. The timeout counter clears on every press.
- WAIT_REL: `leds`=`botoes`. On the first cycle `botoes`==0:
  - if `idx`<`rodada`−1 → `idx`++, WAIT_IN;
  - else if `rodada`==`MAX_ROUND` → WIN;
  - else `rodada`++, `idx`=0, SHOW_OFF.
- WIN: `leds`=4'b1111. LOSE: `leds`=0. Both hold `rodada` until restart.
- `start` in any busy state is ignored. `botoes` outside WAIT_IN/WAIT_REL is ignored.
- Reset in any state aborts immediately to the reset values above.

## Timing
- `seq_addr` changes on the clock edge that updates `idx`. `seq_data` is valid in that same following cycle, and the compare uses it combinationally.
- Playback of round N takes N·(`TICKS_ON`+`TICKS_OFF`) cycles: leading gap, then N on-phases, each followed by a gap except the last, which goes straight to WAIT_IN.
- Press evaluation: the state changes on the edge after the first cycle with `botoes`≠0 and `botoes_q`==0.
- Release: the state changes on the edge after the first cycle with `botoes`==0.
- Timeout: LOSE is entered on the edge ending the `TIMEOUT`-th idle cycle of WAIT_IN.
- A button held while entering WAIT_IN does not count as a press. It must be released and pressed again.

## Structure
- Shared package `genius_pkg`: state enum `genius_state_t`, `COLOR_W`=4, `ADDR_W`=4, `ROUND_W`=5.
- Sub-module `genius_timer`: loadable down-counter with a `done` pulse, used for on/off/timeout phases.
- The sequence decoder is instantiated outside this block, never inside.

## Test plan
Bench params: `TICKS_ON`=3, `TICKS_OFF`=2, `TIMEOUT`=20, `MAX_ROUND`=4. Bench ROM: addr0=0001, addr1=1000, addr2=0100, addr3=1000.
- Reset then `start` pulse → `rodada`=1, `leds`=0 for 2 cycles, then 0001 for 3 cycles, then WAIT_IN with `busy`=1.
- Correct play through all 4 rounds (press 0001, 1000, 0100, 1000, each followed by release) → `win`=1, `leds`=1111, `rodada`=4.
- Round 2, press 0100 at idx 1 → `lose`=1 on the next edge, `leds`=0, `rodada`=2.
- WAIT_IN with no press for 20 cycles → `lose`=1. With a press at cycle 19 → no lose.
- Press 0011 at idx 0 → LOSE. Button held across entry to WAIT_IN → no evaluation until released and re-pressed.
- `reset` asserted mid-SHOW_ON, and `start` asserted mid-playback → reset returns to IDLE with all outputs 0, while `start` causes no change.
